heart_beat_monitor: RTL and testbench
=====================================

// Module: heart_beat_monitor
// PURPOSE
//  Receive end of the heartbeat link. Watches a square-wave heartbeat (hb_pulse from the
//  generator, possibly from another domain) and measures the rising-edge-to-rising-edge period.
//  Checks each period against a [MIN,MAX] window and declares lock / loss.
//  Exports liveness, last period, a sticky loss flag and an error count to top/status regs.
// PARAMETERS
//  CNT_W       16  period counter width; elaboration assert MAX_PERIOD+1 < 2**CNT_W
//  MIN_PERIOD  60  shortest accepted period, clk cycles (assert MIN_PERIOD <= MAX_PERIOD)
//  MAX_PERIOD  68  longest accepted period; no edge by MAX_PERIOD+1 = timeout
//  LOCK_CNT    4   consecutive good periods needed to lock (assert >= 1)
//  ERR_W       8   error counter width
//  SYNC_EN     1   1: 2-flop synchroniser on hb_in; 0: single register stage
// PORTS
//  clk           in   1      system clock
//  reset_n       in   1      asynchronous active-low reset
//  hb_in         in   1      heartbeat input
//  clr_err       in   1      1-cycle pulse: clear hb_lost and err_cnt
//  hb_alive      out  1      1 while state == LOCKED
//  hb_lost       out  1      sticky, set on timeout
//  hb_period     out  CNT_W  last measured period, cycles
//  period_valid  out  1      1-cycle pulse when hb_period updates
//  err_cnt       out  ERR_W  bad-edge + timeout count, saturating
//  state_o       out  2      FSM state: IDLE=0, LOCKING=1, LOCKED=2, LOST=3
// BEHAVIOUR
//  - Reset (async, reset_n=0): every flop 0, state IDLE. All outputs 0.
//  - Input path: SYNC_EN=1 -> 2 flops then edge reg; rise = s & ~s_d.
//    hb_in 0->1 reaches rise 3 clks later (2 clks with SYNC_EN=0).
//  - per counter: +1 every clk, saturates at all-ones. On rise: per <= 1.
//    The value seen at a rise is the period P in clks. good = MIN_PERIOD <= per <= MAX_PERIOD.
//  - timeout = (per == MAX_PERIOD+1) & ~rise & state in {LOCKING, LOCKED}.
//  - good_cnt: width $clog2(LOCK_CNT+1); cleared on every entry to LOCKING.
//  - FSM, one transition per clk:
//     IDLE:    rise -> LOCKING. No period_valid (no previous edge). No timeout.
//     LOCKING: rise&good -> good_cnt++; ->LOCKED when good_cnt+1 == LOCK_CNT.
//              rise&~good -> good_cnt<=0, err++, stay. timeout -> LOST, hb_lost<=1, err++.
//     LOCKED:  rise&good -> stay. rise&~good -> LOCKING, err++.
//              timeout -> LOST, hb_lost<=1, err++.
//     LOST:    rise -> LOCKING. No period_valid; per <= 1.
//  - period_valid/hb_period: on rise in LOCKING or LOCKED, hb_period <= per and
//    period_valid = 1 for that cycle. hb_period holds otherwise.
//  - Rise on the timeout cycle (per == MAX+1): rise wins. Counted as a bad edge, not a loss.
//  - hb_alive, state_o: decoded from the state register, no extra latency.
//  - clr_err vs. events: clr_err wins over an err increment in the same cycle (err_cnt <= 0).
//    A hb_lost set wins over clr_err in the same cycle (hb_lost stays 1).
//  - err_cnt saturates at 2**ERR_W-1; hb_lost clears only via clr_err or reset.
//  - Reset mid-operation: immediate return to all-zero, IDLE. The first edge after reset only arms.
// STRUCTURE
//  - heart_beat_pkg holds: typedef enum logic[1:0] hb_state_e {HB_IDLE, HB_LOCKING,
//    HB_LOCKED, HB_LOST}, plus default period constants shared with the generator.
//  - Sub-module hb_sync_edge (synchroniser + rise detector, SYNC_EN param).
//  - Counters and FSM stay in this module.
// TESTING (defaults; generator-style stimulus, period 64, high 32)
//  1 reset, 64-clk square wave -> first rise arms; 4 periods later hb_alive=1, state_o=2,
//    hb_period=64, err_cnt=0, one period_valid per rise after the first.
//  2 LOCKED, then hold hb_in low -> 69 clks after the last rise: state_o=3, hb_lost=1,
//    hb_alive=0, err_cnt=1.
//  3 from 2, resume 64-clk wave -> LOCKING on first rise, LOCKED after 4 good periods;
//    hb_lost stays 1 until clr_err, which then gives hb_lost=0, err_cnt=0.
//  4 LOCKED, extra rise 20 clks after an edge -> hb_period=20, err_cnt+1, state_o=1, hb_alive=0.
//  5 boundaries: periods 60 and 68 accepted; 59 is bad; 69 is a bad edge (state_o=1, not 3).
//  6 reset_n low mid-LOCKED -> outputs 0 with no clk edge. clr_err on the timeout cycle ->
//    hb_lost=1, err_cnt=0. 300 glitches -> err_cnt holds at 255.

Source files
------------

// File: rtl/heart_beat_pkg.sv
`default_nettype none
// ============================================================================
// Module  : heart_beat_pkg
// Purpose : Shared types and default timing constants for the heartbeat
//           generator / monitor pair.
// Revision: 1.0 - initial release
// ============================================================================
package heart_beat_pkg;

    // Monitor FSM states; the encoding is exported on state_o.
    typedef enum logic [1:0] {
        HB_IDLE    = 2'd0,
        HB_LOCKING = 2'd1,
        HB_LOCKED  = 2'd2,
        HB_LOST    = 2'd3
    } hb_state_e;

    // Nominal heartbeat shape produced by the generator.
    localparam int c_def_period     = 64;
    localparam int c_def_high       = 32;

    // Default acceptance window and lock depth on the receive side.
    localparam int c_def_min_period = 60;
    localparam int c_def_max_period = 68;
    localparam int c_def_lock_cnt   = 4;

endpackage : heart_beat_pkg
`default_nettype wire

// File: rtl/hb_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : hb_sync_edge
// Purpose : Brings the heartbeat into the clk domain and produces a one-cycle
//           rise strobe on each 0->1 transition.
// Revision: 1.0 - initial release
// ============================================================================
module hb_sync_edge #(
    parameter int SYNC_EN = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic hb_in,
    output logic rise
);

    logic w_sync;
    logic r_sync_d;

    generate
        if (SYNC_EN != 0) begin : g_sync2
            logic r_meta;
            logic r_sync;

            // Two-flop synchroniser for a heartbeat from a foreign domain.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_meta <= 1'b0;
                    r_sync <= 1'b0;
                end else begin
                    r_meta <= hb_in;
                    r_sync <= r_meta;
                end
            end

            assign w_sync = r_sync;
        end else begin : g_sync1
            logic r_sync;

            // Single capture stage when the heartbeat is already clk-synchronous.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_sync <= 1'b0;
                end else begin
                    r_sync <= hb_in;
                end
            end

            assign w_sync = r_sync;
        end
    endgenerate

    // Delayed copy of the synchronised level for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_d <= 1'b0;
        end else begin
            r_sync_d <= w_sync;
        end
    end

    assign rise = w_sync & ~r_sync_d;

endmodule : hb_sync_edge
`default_nettype wire

// File: rtl/heart_beat_monitor.sv
`default_nettype none
// ============================================================================
// Module  : heart_beat_monitor
// Purpose : Receive side of the heartbeat link. Measures the rise-to-rise
//           period, checks it against [MIN_PERIOD, MAX_PERIOD], tracks
//           lock/loss and keeps a saturating error count.
// Revision: 1.0 - initial release
// ============================================================================
module heart_beat_monitor
    import heart_beat_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int MIN_PERIOD = c_def_min_period,
    parameter int MAX_PERIOD = c_def_max_period,
    parameter int LOCK_CNT   = c_def_lock_cnt,
    parameter int ERR_W      = 8,
    parameter int SYNC_EN    = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             hb_in,
    input  logic             clr_err,
    output logic             hb_alive,
    output logic             hb_lost,
    output logic [CNT_W-1:0] hb_period,
    output logic             period_valid,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       state_o
);

    localparam int c_gc_w = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]  c_min_period = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0]  c_max_period = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0]  c_timeout    = CNT_W'(MAX_PERIOD + 1);
    localparam logic [c_gc_w-1:0] c_lock_cnt   = c_gc_w'(LOCK_CNT);

    // Parameter sanity: the timeout value must be representable, the window
    // must be non-empty and locking needs at least one good period.
    generate
        if (MAX_PERIOD + 1 >= 2 ** CNT_W) begin : g_chk_cnt_w
            $error("heart_beat_monitor: CNT_W too narrow for MAX_PERIOD+1");
        end
        if (MIN_PERIOD > MAX_PERIOD) begin : g_chk_window
            $error("heart_beat_monitor: MIN_PERIOD must not exceed MAX_PERIOD");
        end
        if (LOCK_CNT < 1) begin : g_chk_lock_cnt
            $error("heart_beat_monitor: LOCK_CNT must be at least 1");
        end
    endgenerate

    logic              w_rise;
    logic              w_good;
    logic              w_timeout;
    logic              w_err_inc;
    logic              w_lost_set;
    logic              w_pv;
    logic [c_gc_w-1:0] w_good_inc;
    logic [c_gc_w-1:0] w_good_cnt_nxt;
    hb_state_e         w_state_nxt;

    hb_state_e         r_state;
    logic [c_gc_w-1:0] r_good_cnt;
    logic [CNT_W-1:0]  r_per;
    logic [CNT_W-1:0]  r_hb_period;
    logic              r_period_valid;
    logic [ERR_W-1:0]  r_err_cnt;
    logic              r_hb_lost;

    hb_sync_edge #(
        .SYNC_EN (SYNC_EN)
    ) u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .hb_in   (hb_in),
        .rise    (w_rise)
    );

    assign w_good     = (r_per >= c_min_period) && (r_per <= c_max_period);
    assign w_good_inc = r_good_cnt + 1'b1;

    // A rise on the timeout cycle takes priority, so timeout requires ~rise.
    assign w_timeout  = (r_per == c_timeout) && !w_rise &&
                        ((r_state == HB_LOCKING) || (r_state == HB_LOCKED));

    // Period counter: restarts at 1 on each rise, otherwise counts and saturates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_per <= '0;
        end else if (w_rise) begin
            r_per <= CNT_W'(1);
        end else if (r_per != '1) begin
            r_per <= r_per + 1'b1;
        end
    end

    // Lock FSM next-state and event decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_good_cnt_nxt = r_good_cnt;
        w_err_inc      = 1'b0;
        w_lost_set     = 1'b0;
        w_pv           = 1'b0;
        case (r_state)
            HB_IDLE: begin
                // First edge has no predecessor, so it only arms the monitor.
                if (w_rise) begin
                    w_state_nxt    = HB_LOCKING;
                    w_good_cnt_nxt = '0;
                end
            end
            HB_LOCKING: begin
                if (w_rise) begin
                    w_pv = 1'b1;
                    if (w_good) begin
                        if (w_good_inc == c_lock_cnt) begin
                            w_state_nxt = HB_LOCKED;
                        end
                        w_good_cnt_nxt = w_good_inc;
                    end else begin
                        w_good_cnt_nxt = '0;
                        w_err_inc      = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = HB_LOST;
                    w_lost_set  = 1'b1;
                    w_err_inc   = 1'b1;
                end
            end
            HB_LOCKED: begin
                if (w_rise) begin
                    w_pv = 1'b1;
                    if (!w_good) begin
                        w_state_nxt    = HB_LOCKING;
                        w_good_cnt_nxt = '0;
                        w_err_inc      = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = HB_LOST;
                    w_lost_set  = 1'b1;
                    w_err_inc   = 1'b1;
                end
            end
            HB_LOST: begin
                // Period across a loss is meaningless; restart locking from scratch.
                if (w_rise) begin
                    w_state_nxt    = HB_LOCKING;
                    w_good_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = HB_IDLE;
                w_good_cnt_nxt = '0;
            end
        endcase
    end

    // Lock FSM state and good-period counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= HB_IDLE;
            r_good_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_cnt_nxt;
        end
    end

    // Capture the measured period and strobe period_valid alongside it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hb_period    <= '0;
            r_period_valid <= 1'b0;
        end else begin
            r_period_valid <= w_pv;
            if (w_pv) begin
                r_hb_period <= r_per;
            end
        end
    end

    // Saturating error count; a same-cycle clear beats an increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_cnt <= '0;
        end else if (clr_err) begin
            r_err_cnt <= '0;
        end else if (w_err_inc && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    // Sticky loss flag; a same-cycle loss beats a clear so no event is missed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hb_lost <= 1'b0;
        end else if (w_lost_set) begin
            r_hb_lost <= 1'b1;
        end else if (clr_err) begin
            r_hb_lost <= 1'b0;
        end
    end

    assign hb_alive     = (r_state == HB_LOCKED);
    assign state_o      = r_state;
    assign hb_lost      = r_hb_lost;
    assign hb_period    = r_hb_period;
    assign period_valid = r_period_valid;
    assign err_cnt      = r_err_cnt;

endmodule : heart_beat_monitor
`default_nettype wire

// File: tb/tb_heart_beat_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_heart_beat_monitor
// Purpose : Directed self-checking bench for heart_beat_monitor with default
//           parameters and a generator-style square-wave heartbeat.
// Revision: 1.0 - initial release
// ============================================================================
module tb_heart_beat_monitor;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        hb_in   = 1'b0;
    logic        clr_err = 1'b0;
    logic        hb_alive;
    logic        hb_lost;
    logic [15:0] hb_period;
    logic        period_valid;
    logic [7:0]  err_cnt;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;
    int pv_cnt = 0;

    heart_beat_monitor dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .hb_in        (hb_in),
        .clr_err      (clr_err),
        .hb_alive     (hb_alive),
        .hb_lost      (hb_lost),
        .hb_period    (hb_period),
        .period_valid (period_valid),
        .err_cnt      (err_cnt),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    // Count period_valid pulses.
    always @(posedge clk) begin
        if (period_valid === 1'b1) pv_cnt <= pv_cnt + 1;
    end

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One heartbeat period: rising edge now, next rising edge p cycles later.
    task automatic send_period(input int p, input int high);
        hb_in = 1'b1;
        tick(high);
        hb_in = 1'b0;
        tick(p - high);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- reset ----
        tick(3);
        chk("rst_state", 32'(state_o), 0);
        chk("rst_alive", 32'(hb_alive), 0);
        chk("rst_lost", 32'(hb_lost), 0);
        chk("rst_period", 32'(hb_period), 0);
        chk("rst_err", 32'(err_cnt), 0);
        chk("rst_pv", 32'(period_valid), 0);
        reset_n = 1'b1;
        tick(2);

        // ---- 1: lock on a 64-cycle wave ----
        send_period(64, 32);
        chk("t1_arm_state", 32'(state_o), 1);
        chk("t1_arm_pv", 32'(pv_cnt), 0);
        repeat (4) send_period(64, 32);
        chk("t1_state", 32'(state_o), 2);
        chk("t1_alive", 32'(hb_alive), 1);
        chk("t1_period", 32'(hb_period), 64);
        chk("t1_err", 32'(err_cnt), 0);
        chk("t1_pv_count", 32'(pv_cnt), 4);

        // ---- 2: heartbeat stops; timeout 69 cycles after the last rise ----
        hb_in = 1'b1;
        tick(32);
        hb_in = 1'b0;
        tick(39);
        chk("t2_pre_state", 32'(state_o), 2);
        tick(1);
        chk("t2_state", 32'(state_o), 3);
        chk("t2_lost", 32'(hb_lost), 1);
        chk("t2_alive", 32'(hb_alive), 0);
        chk("t2_err", 32'(err_cnt), 1);
        chk("t2_pv_count", 32'(pv_cnt), 5);

        // ---- 3: recovery, sticky loss, clr_err ----
        send_period(64, 32);
        chk("t3_relock_state", 32'(state_o), 1);
        chk("t3_relock_pv", 32'(pv_cnt), 5);
        repeat (4) send_period(64, 32);
        chk("t3_state", 32'(state_o), 2);
        chk("t3_lost_sticky", 32'(hb_lost), 1);
        chk("t3_err", 32'(err_cnt), 1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("t3_clr_lost", 32'(hb_lost), 0);
        chk("t3_clr_err", 32'(err_cnt), 0);

        // ---- 4: extra rise 20 cycles after a good edge ----
        send_period(20, 10);
        hb_in = 1'b1;
        tick(3);
        chk("t4_period", 32'(hb_period), 20);
        chk("t4_err", 32'(err_cnt), 1);
        chk("t4_state", 32'(state_o), 1);
        chk("t4_alive", 32'(hb_alive), 0);
        tick(29);
        hb_in = 1'b0;
        tick(32);
        repeat (4) send_period(64, 32);
        chk("t4_relock", 32'(state_o), 2);

        // ---- 5: window boundaries ----
        send_period(60, 30);
        send_period(68, 34);
        chk("t5_p60_period", 32'(hb_period), 60);
        chk("t5_p60_state", 32'(state_o), 2);
        send_period(59, 30);
        chk("t5_p68_period", 32'(hb_period), 68);
        chk("t5_p68_state", 32'(state_o), 2);
        chk("t5_p68_err", 32'(err_cnt), 1);
        send_period(64, 32);
        chk("t5_p59_period", 32'(hb_period), 59);
        chk("t5_p59_state", 32'(state_o), 1);
        chk("t5_p59_err", 32'(err_cnt), 2);
        repeat (4) send_period(64, 32);
        chk("t5_relock", 32'(state_o), 2);
        send_period(69, 34);
        send_period(64, 32);
        chk("t5_p69_period", 32'(hb_period), 69);
        chk("t5_p69_state", 32'(state_o), 1);
        chk("t5_p69_lost", 32'(hb_lost), 0);
        chk("t5_p69_err", 32'(err_cnt), 3);
        repeat (4) send_period(64, 32);
        chk("t5_relock2", 32'(state_o), 2);

        // ---- 6a: asynchronous reset while LOCKED ----
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_state", 32'(state_o), 0);
        chk("t6_rst_alive", 32'(hb_alive), 0);
        chk("t6_rst_period", 32'(hb_period), 0);
        chk("t6_rst_err", 32'(err_cnt), 0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        send_period(64, 32);
        chk("t6_arm_state", 32'(state_o), 1);
        repeat (4) send_period(64, 32);
        chk("t6_lock_state", 32'(state_o), 2);
        chk("t6_lock_err", 32'(err_cnt), 0);

        // ---- 6b: clr_err on the timeout cycle ----
        hb_in = 1'b1;
        tick(32);
        hb_in = 1'b0;
        tick(39);
        chk("t6_pre_to_state", 32'(state_o), 2);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("t6_to_state", 32'(state_o), 3);
        chk("t6_to_lost", 32'(hb_lost), 1);
        chk("t6_to_err", 32'(err_cnt), 0);

        // ---- 6c: 300 glitches saturate the error count ----
        for (int i = 0; i < 300; i++) begin
            hb_in = 1'b1;
            tick(1);
            hb_in = 1'b0;
            tick(1);
        end
        tick(4);
        chk("t6_sat_err", 32'(err_cnt), 255);
        chk("t6_sat_state", 32'(state_o), 1);
        chk("t6_sat_lost", 32'(hb_lost), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_heart_beat_monitor
`default_nettype wire
